// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and geometry helpers for the associative cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  // Controller states: serve hits, flush a dirty victim, fetch, install.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_UPDATE    = 2'd3
  } state_t;

  // Byte-offset field width: word select plus the two byte bits.
  function automatic int offset_bits(input int block_words);
    return $clog2(block_words) + 2;
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int block_words);
    return 32 - offset_bits(block_words) - index_bits(sets);
  endfunction

  // Selector width that never collapses to zero for single-entry fields.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Age matrix per set: one bit per ordered pair of ways.
  function automatic int lru_bits(input int ways);
    return ways * ways;
  endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_data_cache_if.sv
// ============================================================================
// Module      : assoc_data_cache_if
// Description : CPU-side request bus and memory-side block bus of the cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface assoc_data_cache_if #(
  parameter int BLOCK_WORDS = 4
);
  import cache_pkg::*;

  localparam int AW = 32 - offset_bits(BLOCK_WORDS);

  logic                     read;
  logic                     write;
  logic [31:0]              address;
  logic [31:0]              writedata;
  logic [3:0]               byte_en;
  logic [31:0]              readdata;
  logic                     busywait;
  logic                     hit;
  logic                     mem_read;
  logic                     mem_write;
  logic [AW-1:0]            mem_address;
  logic [32*BLOCK_WORDS-1:0] mem_writedata;
  logic [32*BLOCK_WORDS-1:0] mem_readdata;
  logic                     mem_busywait;

  // Environment view: drives CPU requests and memory responses.
  modport master (
    output read, write, address, writedata, byte_en, mem_readdata, mem_busywait,
    input  readdata, busywait, hit, mem_read, mem_write, mem_address, mem_writedata
  );

  // Cache view.
  modport slave (
    input  read, write, address, writedata, byte_en, mem_readdata, mem_busywait,
    output readdata, busywait, hit, mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

`default_nettype wire

// File: rtl/cache_lru.sv
// ============================================================================
// Module      : cache_lru
// Description : Per-set age-matrix LRU tracker; reports the LRU way of a set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_lru
  import cache_pkg::*;
#(
  parameter  int WAYS = 2,
  parameter  int SETS = 8,
  localparam int IW   = index_bits(SETS),
  localparam int WW   = sel_bits(WAYS)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [IW-1:0] i_set,
  input  wire logic [WW-1:0] i_touch_way,
  input  wire logic          i_touch_en,
  output logic      [WW-1:0] o_victim
);

  localparam int LW = lru_bits(WAYS);

  // Bit i*WAYS+j set means way i was used more recently than way j.
  logic [LW-1:0] r_age [SETS];
  logic          w_found;

  // The LRU way is the one not newer than any other (all-zero row).
  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found && (r_age[i_set][i*WAYS +: WAYS] == '0)) begin
        o_victim = WW'(i);
        w_found  = 1'b1;
      end
    end
  end

  // Touch: the way becomes newer than all others and older than none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_age[s] <= '0;
    end else if (i_touch_en) begin
      for (int i = 0; i < WAYS; i++) begin
        for (int j = 0; j < WAYS; j++) begin
          if ((WW'(i) == i_touch_way) && (i != j))
            r_age[i_set][i*WAYS+j] <= 1'b1;
          else if (WW'(j) == i_touch_way)
            r_age[i_set][i*WAYS+j] <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/assoc_data_cache.sv
// ============================================================================
// Module      : assoc_data_cache
// Description : N-way set-associative write-back/write-allocate data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module assoc_data_cache
  import cache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4
) (
  input wire logic           clk,
  input wire logic           rst_n,
  assoc_data_cache_if.slave  bus
);

  localparam int OFF = offset_bits(BLOCK_WORDS);
  localparam int IW  = index_bits(SETS);
  localparam int TW  = tag_bits(SETS, BLOCK_WORDS);
  localparam int WSW = sel_bits(BLOCK_WORDS);
  localparam int WW  = sel_bits(WAYS);
  localparam int BW  = 32 * BLOCK_WORDS;

  logic          r_valid [SETS][WAYS];
  logic          r_dirty [SETS][WAYS];
  logic [TW-1:0] r_tag   [SETS][WAYS];
  logic [BW-1:0] r_data  [SETS][WAYS];

  state_t        r_state, w_next;
  logic [TW-1:0] r_req_tag;
  logic [IW-1:0] r_req_idx;
  logic [WW-1:0] r_victim;

  logic [TW-1:0]  w_tag;
  logic [IW-1:0]  w_idx;
  logic [WSW-1:0] w_word;
  logic           w_req, w_match, w_hit, w_any_invalid;
  logic [WW-1:0]  w_hit_way, w_lru_way, w_victim;
  logic [BW-1:0]  w_hit_block, w_wr_block;
  logic [31:0]    w_hit_word;
  logic           w_unused;

  assign w_tag    = bus.address[31 -: TW];
  assign w_idx    = bus.address[OFF +: IW];
  assign w_unused = ^bus.address[1:0];

  generate
    if (BLOCK_WORDS > 1) begin : g_word_sel
      assign w_word = bus.address[2 +: WSW];
    end else begin : g_word_single
      assign w_word = '0;
    end
  endgenerate

  assign w_req = bus.read | bus.write;

  // Tag compare across every way of the indexed set.
  always_comb begin
    w_match   = 1'b0;
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
        w_match   = 1'b1;
        w_hit_way = WW'(i);
      end
    end
  end

  // Hits are only served while the controller is idle.
  assign w_hit       = w_req & w_match & (r_state == ST_IDLE);
  assign w_hit_block = r_data[w_idx][w_hit_way];

  // Extract the addressed word and build the byte-merged block for stores.
  always_comb begin
    w_hit_word = '0;
    w_wr_block = w_hit_block;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (WSW'(i) == w_word) begin
        w_hit_word = w_hit_block[i*32 +: 32];
        for (int b = 0; b < 4; b++) begin
          if (bus.byte_en[b]) w_wr_block[i*32+b*8 +: 8] = bus.writedata[b*8 +: 8];
        end
      end
    end
  end

  assign bus.readdata      = w_hit ? w_hit_word : 32'd0;
  assign bus.hit           = w_hit;
  assign bus.mem_writedata = r_data[r_req_idx][r_victim];

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set       (w_idx),
    .i_touch_way (w_hit_way),
    .i_touch_en  (w_hit),
    .o_victim    (w_lru_way)
  );

  // Victim: fill empty ways lowest-first before evicting the LRU way.
  always_comb begin
    w_victim      = w_lru_way;
    w_any_invalid = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_any_invalid && !r_valid[w_idx][i]) begin
        w_victim      = WW'(i);
        w_any_invalid = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and memory-side handshake.
  always_comb begin
    w_next          = r_state;
    bus.busywait    = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !w_match) begin
          bus.busywait = 1'b1;
          w_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                   ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        bus.busywait    = 1'b1;
        bus.mem_write   = 1'b1;
        bus.mem_address = {r_tag[r_req_idx][r_victim], r_req_idx};
        if (!bus.mem_busywait) w_next = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        bus.busywait    = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_address = {r_req_tag, r_req_idx};
        if (!bus.mem_busywait) w_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        bus.busywait = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the missing request so the fill completes even if it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_tag <= '0;
      r_req_idx <= '0;
      r_victim  <= '0;
    end else if ((r_state == ST_IDLE) && w_req && !w_match) begin
      r_req_tag <= w_tag;
      r_req_idx <= w_idx;
      r_victim  <= w_victim;
    end
  end

  // Line status: install clean on fill, mark dirty on store hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else if (r_state == ST_UPDATE) begin
      r_valid[r_req_idx][r_victim] <= 1'b1;
      r_dirty[r_req_idx][r_victim] <= 1'b0;
    end else if (w_hit && bus.write) begin
      r_dirty[w_idx][w_hit_way] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the line is valid.
  always_ff @(posedge clk) begin
    if (r_state == ST_UPDATE) begin
      r_tag[r_req_idx][r_victim]  <= r_req_tag;
      r_data[r_req_idx][r_victim] <= bus.mem_readdata;
    end else if (w_hit && bus.write) begin
      r_data[w_idx][w_hit_way] <= w_wr_block;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_assoc_data_cache.sv
// ============================================================================
// Module      : tb_assoc_data_cache
// Description : Self-checking bench for assoc_data_cache against a
//               transaction-level cache/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_assoc_data_cache;
  import cache_pkg::*;

  localparam int WAYS = 2, SETS = 8, BLOCK_WORDS = 4;
  localparam int OFF = 4, IW = 3, TW = 25, AW = 28, BW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_data_cache_if #(.BLOCK_WORDS(BLOCK_WORDS)) bus ();

  assoc_data_cache #(
    .WAYS        (WAYS),
    .SETS        (SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-cycle expectations, written by the driver at each falling edge.
  logic          chk_en = 1'b0;
  logic          e_busy, e_hit, e_mr, e_mw;
  logic [31:0]   e_rdata;
  logic [AW-1:0] e_maddr;
  logic [BW-1:0] e_mwdata;

  // Last memory-side activity seen on the DUT, for literal pins.
  logic [AW-1:0] last_mr_addr = '1;
  logic [AW-1:0] last_mw_addr = '1;
  logic [31:0]   last_mw_word0 = '1;

  // Pending CPU request applied at the next falling edge.
  logic          q_rd = 1'b0, q_wr = 1'b0;
  logic [31:0]   q_addr = '0, q_wd = '0;
  logic [3:0]    q_be = '0;

  // Reference model: lines, recency stamps and backing memory.
  bit            m_valid [SETS][WAYS];
  bit            m_dirty [SETS][WAYS];
  logic [TW-1:0] m_tag   [SETS][WAYS];
  logic [BW-1:0] m_data  [SETS][WAYS];
  longint        m_stamp [SETS][WAYS];
  longint        now_t = 0;
  logic [BW-1:0] mem [bit [AW-1:0]];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mem_get(input logic [AW-1:0] a);
    logic [BW-1:0] blk;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < BLOCK_WORDS; i++) blk[i*32 +: 32] = 32'hC0DE_0000 ^ {a, 4'(i*4)};
    return blk;
  endfunction

  function automatic int pick_victim(input int s);
    int v;
    for (int i = 0; i < WAYS; i++) if (!m_valid[s][i]) return i;
    v = 0;
    for (int i = 1; i < WAYS; i++) if (m_stamp[s][i] < m_stamp[s][v]) v = i;
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_stamp[s][w] = 0;
      end
  endtask

  // Compare process: checks every DUT output the model defines this cycle.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("busywait", BW'(bus.busywait), BW'(e_busy));
      chk("hit", BW'(bus.hit), BW'(e_hit));
      chk("readdata", BW'(bus.readdata), BW'(e_rdata));
      chk("mem_read", BW'(bus.mem_read), BW'(e_mr));
      chk("mem_write", BW'(bus.mem_write), BW'(e_mw));
      if (e_mr || e_mw) chk("mem_address", BW'(bus.mem_address), BW'(e_maddr));
      if (e_mw) chk("mem_writedata", bus.mem_writedata, e_mwdata);
    end
    if (bus.mem_read) last_mr_addr = bus.mem_address;
    if (bus.mem_write) begin
      last_mw_addr  = bus.mem_address;
      last_mw_word0 = bus.mem_writedata[31:0];
    end
  end

  task automatic cyc(input logic busy, input logic hit, input logic mr, input logic mw,
                     input logic [31:0] rdata, input logic [AW-1:0] maddr,
                     input logic [BW-1:0] mwdata, input logic mbw, input logic [BW-1:0] mrdata);
    @(negedge clk);
    bus.read = q_rd; bus.write = q_wr; bus.address = q_addr;
    bus.writedata = q_wd; bus.byte_en = q_be;
    bus.mem_busywait = mbw; bus.mem_readdata = mrdata;
    e_busy = busy; e_hit = hit; e_mr = mr; e_mw = mw;
    e_rdata = rdata; e_maddr = maddr; e_mwdata = mwdata;
    chk_en = 1'b1;
  endtask

  task automatic idle();
    q_rd = 0; q_wr = 0; q_be = '0;
    cyc(0, 0, 0, 0, '0, '0, '0, 1, '0);
  endtask

  // One CPU request from issue to the cycle it is served.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    int s, wi, hw, v, lw, lr;
    logic [TW-1:0] t;
    logic [AW-1:0] va, ra;
    logic [BW-1:0] blk;
    logic [31:0] word;
    q_rd = rd; q_wr = wr; q_addr = addr; q_wd = wd; q_be = be;
    s = int'(addr[OFF +: IW]); t = addr[31 -: TW]; wi = int'(addr[3:2]);
    hw = -1;
    for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) hw = i;
    if (hw < 0) begin
      v = pick_victim(s);
      cyc(1, 0, 0, 0, '0, '0, '0, 1, '0);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        lw = $urandom_range(1, 3);
        va = {m_tag[s][v], 3'(s)};
        for (int k = 0; k < lw; k++)
          cyc(1, 0, 0, 1, '0, va, m_data[s][v], (k == lw - 1) ? 1'b0 : 1'b1, '0);
        mem[va] = m_data[s][v];
      end
      lr = $urandom_range(1, 3);
      ra = {t, 3'(s)};
      blk = mem_get(ra);
      for (int k = 0; k < lr; k++)
        cyc(1, 0, 1, 0, '0, ra, '0, (k == lr - 1) ? 1'b0 : 1'b1, blk);
      cyc(1, 0, 0, 0, '0, '0, '0, 1, blk);
      m_valid[s][v] = 1; m_dirty[s][v] = 0; m_tag[s][v] = t; m_data[s][v] = blk;
      hw = v;
    end
    word = m_data[s][hw][wi*32 +: 32];
    cyc(0, 1, 0, 0, word, '0, '0, 1, '0);
    now_t++;
    m_stamp[s][hw] = now_t;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_data[s][hw][wi*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[s][hw] = 1;
    end
  endtask

  initial begin
    logic [31:0] a;
    int op;
    bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0; bus.byte_en = '0;
    bus.mem_busywait = 1; bus.mem_readdata = '0;
    model_reset();

    // Reset state
    idle();
    #3;
    chk("rst_busywait", BW'(bus.busywait), '0);
    chk("rst_mem_read", BW'(bus.mem_read), '0);
    idle();
    #1 rst_n = 1'b1;
    idle();

    // Cold read of 0x40
    run_req(1, 0, 32'h40, '0, 4'h0);
    #3;
    chk("cold_readdata", BW'(bus.readdata), BW'(32'hC0DE_0040));
    chk("cold_hit", BW'(bus.hit), BW'(1'b1));
    chk("cold_block_addr", BW'(last_mr_addr), BW'(28'h004));

    // Store then load hit
    run_req(0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    run_req(1, 0, 32'h40, '0, 4'h0);
    #3;
    chk("sw_lw_readdata", BW'(bus.readdata), BW'(32'hDEAD_BEEF));
    chk("sw_lw_busywait", BW'(bus.busywait), '0);

    // Byte store merge
    run_req(0, 1, 32'h40, 32'h1122_3344, 4'hF);
    run_req(0, 1, 32'h41, 32'h0000_AA00, 4'b0010);
    run_req(1, 0, 32'h40, '0, 4'h0);
    #3;
    chk("sb_merge", BW'(bus.readdata), BW'(32'h1122_AA44));

    // LRU: A, B fill set 0; touch A; C evicts B
    run_req(1, 0, 32'h000, '0, 4'h0);
    run_req(1, 0, 32'h080, '0, 4'h0);
    run_req(1, 0, 32'h000, '0, 4'h0);
    run_req(1, 0, 32'h100, '0, 4'h0);
    chk("lru_fetch_c", BW'(last_mr_addr), BW'(28'h010));
    run_req(1, 0, 32'h000, '0, 4'h0);
    #3;
    chk("lru_a_still_hits", BW'(bus.hit), BW'(1'b1));

    // Dirty eviction of A
    run_req(0, 1, 32'h000, 32'h5555_AAAA, 4'hF);
    run_req(1, 0, 32'h100, '0, 4'h0);
    run_req(1, 0, 32'h180, '0, 4'h0);
    chk("wb_addr", BW'(last_mw_addr), BW'(28'h000));
    chk("wb_data", BW'(last_mw_word0), BW'(32'h5555_AAAA));
    chk("wb_then_fetch", BW'(last_mr_addr), BW'(28'h018));

    // Reset asserted while a fill is outstanding
    q_rd = 1; q_wr = 0; q_addr = 32'h70; q_be = '0;
    cyc(1, 0, 0, 0, '0, '0, '0, 1, '0);
    cyc(1, 0, 1, 0, '0, 28'h007, '0, 1, '0);
    cyc(1, 0, 1, 0, '0, 28'h007, '0, 1, '0);
    #3;
    rst_n = 1'b0; bus.read = 1'b0; q_rd = 0;
    #1;
    chk("rst_mid_mem_read", BW'(bus.mem_read), '0);
    chk("rst_mid_busywait", BW'(bus.busywait), '0);
    chk("rst_mid_hit", BW'(bus.hit), '0);
    model_reset();
    idle();
    #1 rst_n = 1'b1;
    idle();
    run_req(1, 0, 32'h40, '0, 4'h0);
    chk("post_rst_refetch", BW'(last_mr_addr), BW'(28'h004));

    // Randomised traffic over a few conflicting tags in four sets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) idle();
      a = {25'($urandom_range(0, 5)), 3'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 9);
      run_req(op < 5 || op == 9, op >= 5, a, $urandom, 4'($urandom_range(1, 15)));
    end

    idle();
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
